conv_bias_relu: RTL

// - Post-accumulation stage fed by the conv MAC array, one partial sum (psum) per output channel per beat.
// - Fetches the channel bias from the local bias memory through its read port and rescales the psum.
// - Adds the bias, saturates the result and optionally applies ReLU.
// - Emits a 16-bit activation stream to the output buffer over a valid/ready handshake.

---
 rtl/conv_bias_relu.sv | 135 +++++++++++++
 1 files changed

// File: rtl/conv_bias_relu.sv
// ============================================================================
// Module   : conv_bias_relu
// Purpose  : Post-MAC stage: round Q16.16 psum to Q8.8, add per-channel bias,
//            saturate, optional ReLU (macro RELU_EN), valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_bias_relu #(
    parameter int CH_NUM     = 10,
    parameter int PSUM_W     = 32,
    parameter int DATA_W     = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] in_psum,
    output logic              read_bias_signal,
    output logic [15:0]       read_bias_addr,
    input  logic [15:0]       read_bias_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int C_SUM_W = PSUM_W - FRAC_SHIFT + 1;
    localparam int C_CNT_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [C_CNT_W-1:0]        C_CH_LAST = C_CNT_W'(CH_NUM - 1);
    localparam logic signed [C_SUM_W-1:0] C_SAT_MAX = C_SUM_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [C_SUM_W-1:0] C_SAT_MIN = ~C_SAT_MAX;
    localparam logic signed [PSUM_W:0]    C_ROUND   = (PSUM_W + 1)'(1 << (FRAC_SHIFT - 1));

    logic [C_CNT_W-1:0]        ch_cnt_q, ch_cnt_d;
    logic                      s1_valid_q, s1_valid_d;
    logic signed [C_SUM_W-1:0] s1_sum_q, s1_sum_d;
    logic                      s1_last_q, s1_last_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic                      out_last_q, out_last_d;

    logic                      s2_free, s1_free, accept;
    logic [C_CNT_W-1:0]        ch_cur;
    logic signed [PSUM_W:0]    psum_rnd;
    logic signed [C_SUM_W-1:0] bias_ext;
    logic [DATA_W-1:0]         sat_val, act_val;

    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        s1_free  = !s1_valid_q || s2_free;
        in_ready = s1_free && !rst;
        accept   = in_valid && in_ready;

        // A clear in the accept cycle makes that beat channel 0
        ch_cur           = clear_cnt ? '0 : ch_cnt_q;
        read_bias_signal = accept;
        read_bias_addr   = 16'(ch_cur);

        // One extra bit keeps the rounding add from overflowing
        psum_rnd = $signed({in_psum[PSUM_W-1], in_psum}) + C_ROUND;
        bias_ext = $signed({{(C_SUM_W - 16){read_bias_data[15]}}, read_bias_data});

        ch_cnt_d = ch_cnt_q;
        if (accept) begin
            ch_cnt_d = (ch_cur == C_CH_LAST) ? '0 : ch_cur + C_CNT_W'(1);
        end else if (clear_cnt) begin
            ch_cnt_d = '0;
        end

        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_last_d  = s1_last_q;
        if (s1_free) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_sum_d  = C_SUM_W'(psum_rnd >>> FRAC_SHIFT) + bias_ext;
                s1_last_d = (ch_cur == C_CH_LAST);
            end
        end

        if (s1_sum_q > C_SAT_MAX) begin
            sat_val = DATA_W'(C_SAT_MAX);
        end else if (s1_sum_q < C_SAT_MIN) begin
            sat_val = DATA_W'(C_SAT_MIN);
        end else begin
            sat_val = s1_sum_q[DATA_W-1:0];
        end
`ifdef RELU_EN
        act_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
        act_val = sat_val;
`endif

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = act_val;
                out_last_d = s1_last_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            ch_cnt_q    <= ch_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

`default_nettype wire
